// File: rtl/riscv_pkg.sv
// Shared integer-pipeline definitions: datapath width, register index
// width, register-file depth and the x0 constant, plus the commit
// qualifier used by the writeback stage.
package riscv_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // A writeback commits only when enabled and not aimed at x0.
    function automatic logic is_commit(input logic regwrite, input reg_idx_t rd);
        return regwrite && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One decode-stage read port: x0 returns zero, a register being written
// in the same cycle returns the incoming value (write-through bypass),
// everything else reads the architectural array.
module regfile_read_port #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic [4:0]                 rs_idx_i,
    input  logic [4:0]                 wr_idx_i,
    input  logic                       byp_en_i,
    input  logic [XLEN-1:0]            wr_data_i,
    input  logic [NREG-1:0][XLEN-1:0]  regs_i,
    output logic [XLEN-1:0]            rd_data_o
);

    import riscv_pkg::*;

    reg_idx_t rs_idx;
    reg_idx_t wr_idx;

    assign rs_idx = rs_idx_i;
    assign wr_idx = wr_idx_i;

    // Priority: zero register, then same-cycle bypass, then stored value.
    always_comb begin
        // NOTE: assign a default first so every path drives the output and no latch is inferred.
        rd_data_o = regs_i[rs_idx];
        if (rs_idx == REG_ZERO) begin
            rd_data_o = '0;
        end else if (byp_en_i && (rs_idx == wr_idx)) begin
            rd_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and integer register file. Picks the writeback value
// (load data or ALU result), commits it to the 32-entry array, serves two
// bypassed decode read ports and counts retired register writes.
module wb_regfile #(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREG  = riscv_pkg::NREG,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WB_MemtoReg,
    input  logic             WB_RegWrite,
    input  logic [XLEN-1:0]  WB_MemData,
    input  logic [XLEN-1:0]  WB_ALUresult,
    input  logic [4:0]       WB_rdReg,
    input  logic [4:0]       ID_rs1Reg,
    input  logic [4:0]       ID_rs2Reg,
    output logic [XLEN-1:0]  ID_rs1Data,
    output logic [XLEN-1:0]  ID_rs2Data,
    output logic [XLEN-1:0]  WB_WriteData,
    output logic [CNT_W-1:0] wb_count
);

    import riscv_pkg::*;

    logic                      we;
    logic                      byp_en;
    logic [NREG-1:0][XLEN-1:0] regs_q;
    logic [NREG-1:0][XLEN-1:0] regs_d;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;

    // Writeback data select; not gated by reset so forwarding sees it raw.
    assign WB_WriteData = WB_MemtoReg ? WB_MemData : WB_ALUresult;

    // An X on the index or data while RegWrite is low still yields we=0.
    assign we     = is_commit(WB_RegWrite, WB_rdReg);
    assign byp_en = rst_n && we;

    // Next-state array: the addressed entry takes the writeback value; x0 stays zero.
    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[WB_rdReg] = WB_WriteData;
        end
        regs_d[REG_ZERO] = '0;
    end

    // Architectural register array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the whole array is reset because software expects every register to read 0 after reset, so this cannot map to a RAM macro.
            regs_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            regs_q <= regs_d;
        end
    end

    // Retired-write counter; wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (we) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_count = cnt_q;

    regfile_read_port #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rs1_port (
        .rs_idx_i  (ID_rs1Reg),
        .wr_idx_i  (WB_rdReg),
        .byp_en_i  (byp_en),
        .wr_data_i (WB_WriteData),
        .regs_i    (regs_q),
        .rd_data_o (ID_rs1Data)
    );

    regfile_read_port #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rs2_port (
        .rs_idx_i  (ID_rs2Reg),
        .wr_idx_i  (WB_rdReg),
        .byp_en_i  (byp_en),
        .wr_data_i (WB_WriteData),
        .regs_i    (regs_q),
        .rd_data_o (ID_rs2Data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a vector table for single-cycle
// behaviour plus hand sequences for reset, X inputs and counter wrap.
module tb_wb_regfile;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             wb_memtoreg;
    logic             wb_regwrite;
    logic [XLEN-1:0]  wb_memdata;
    logic [XLEN-1:0]  wb_aluresult;
    logic [4:0]       wb_rdreg;
    logic [4:0]       id_rs1reg;
    logic [4:0]       id_rs2reg;
    logic [XLEN-1:0]  id_rs1data;
    logic [XLEN-1:0]  id_rs2data;
    logic [XLEN-1:0]  wb_writedata;
    logic [CNT_W-1:0] wb_count;

    int total = 0;
    int bad   = 0;

    wb_regfile #(
        .XLEN  (XLEN),
        .NREG  (32),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .WB_MemtoReg  (wb_memtoreg),
        .WB_RegWrite  (wb_regwrite),
        .WB_MemData   (wb_memdata),
        .WB_ALUresult (wb_aluresult),
        .WB_rdReg     (wb_rdreg),
        .ID_rs1Reg    (id_rs1reg),
        .ID_rs2Reg    (id_rs2reg),
        .ID_rs1Data   (id_rs1data),
        .ID_rs2Data   (id_rs2data),
        .WB_WriteData (wb_writedata),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            regwrite;
        logic            memtoreg;
        logic [4:0]      rd;
        logic [XLEN-1:0] memdata;
        logic [XLEN-1:0] alures;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] exp_rs1;
        logic [XLEN-1:0] exp_rs2;
        logic [XLEN-1:0] exp_wd;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs [12];

    localparam logic [XLEN-1:0] MEMV = 64'hFFFF_FFFF_0000_0001;
    localparam logic [XLEN-1:0] TOPV = 64'h8000_0000_0000_0000;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [XLEN-1:0] md, input logic [XLEN-1:0] ar,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        wb_regwrite  = rw;
        wb_memtoreg  = m2r;
        wb_rdreg     = rd;
        wb_memdata   = md;
        wb_aluresult = ar;
        id_rs1reg    = rs1;
        id_rs2reg    = rs2;
    endtask

    initial begin
        //                regwr m2r rd     memdata          alures           rs1    rs2    exp_rs1          exp_rs2          exp_wd           cnt
        vecs[0]  = '{1'b1, 1'b0, 5'd3,  64'h9999,        64'h1234,        5'd3,  5'd0,  64'h1234,        64'h0,           64'h1234,        4'd1};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  64'h0,           64'h0,           5'd3,  5'd3,  64'h1234,        64'h1234,        64'h0,           4'd1};
        vecs[2]  = '{1'b1, 1'b1, 5'd7,  MEMV,            64'h77,          5'd7,  5'd7,  MEMV,            MEMV,            MEMV,            4'd2};
        vecs[3]  = '{1'b0, 1'b0, 5'd0,  64'h0,           64'h0,           5'd7,  5'd3,  MEMV,            64'h1234,        64'h0,           4'd2};
        vecs[4]  = '{1'b1, 1'b0, 5'd0,  64'h0,           64'hAAAA,        5'd0,  5'd0,  64'h0,           64'h0,           64'hAAAA,        4'd2};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  64'h0,           64'h0,           5'd0,  5'd0,  64'h0,           64'h0,           64'h0,           4'd2};
        vecs[6]  = '{1'b0, 1'b0, 5'd9,  64'h0,           64'h55,          5'd9,  5'd9,  64'h0,           64'h0,           64'h55,          4'd2};
        vecs[7]  = '{1'b0, 1'b0, 5'd0,  64'h0,           64'h0,           5'd9,  5'd7,  64'h0,           MEMV,            64'h0,           4'd2};
        vecs[8]  = '{1'b1, 1'b0, 5'd3,  64'h0,           64'hBEEF,        5'd3,  5'd7,  64'hBEEF,        MEMV,            64'hBEEF,        4'd3};
        vecs[9]  = '{1'b0, 1'b0, 5'd0,  64'h0,           64'h0,           5'd3,  5'd3,  64'hBEEF,        64'hBEEF,        64'h0,           4'd3};
        vecs[10] = '{1'b1, 1'b1, 5'd31, TOPV,            64'h1,           5'd31, 5'd30, TOPV,            64'h0,           TOPV,            4'd4};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  64'h0,           64'h0,           5'd31, 5'd31, TOPV,            TOPV,            64'h0,           4'd4};

        // Reset with a write pending: nothing commits, bypass is off, data mux still live.
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd0, 5'd0);
        #1 rst_n = 1'b0;
        drive(1'b1, 1'b0, 5'd5, 64'h0, 64'hDEAD, 5'd5, 5'd5);
        tick();
        tick();
        check("rst_rs1", id_rs1data, 64'h0);
        check("rst_rs2", id_rs2data, 64'h0);
        check("rst_cnt", {60'h0, wb_count}, 64'h0);
        check("rst_wd_ungated", wb_writedata, 64'hDEAD);
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd5, 5'd0);
        #1 rst_n = 1'b1;
        tick();
        check("post_rst_x5", id_rs1data, 64'h0);
        check("post_rst_cnt", {60'h0, wb_count}, 64'h0);

        // Table: combinational reads before the edge, counter after it.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].regwrite, vecs[i].memtoreg, vecs[i].rd, vecs[i].memdata,
                  vecs[i].alures, vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("v%0d_rs1", i), id_rs1data, vecs[i].exp_rs1);
            check($sformatf("v%0d_rs2", i), id_rs2data, vecs[i].exp_rs2);
            check($sformatf("v%0d_wd", i), wb_writedata, vecs[i].exp_wd);
            tick();
            check($sformatf("v%0d_cnt", i), {60'h0, wb_count}, {60'h0, vecs[i].exp_cnt});
        end

        // Unknown index and data with the write disabled must leave state alone.
        drive(1'b0, 1'bx, 5'bx, 'x, 'x, 5'd3, 5'd7);
        tick();
        check("xin_rs1", id_rs1data, 64'hBEEF);
        check("xin_rs2", id_rs2data, MEMV);
        check("xin_cnt", {60'h0, wb_count}, 64'h4);

        // Twelve more commits take the 4-bit counter from 4 through 15 to 0.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 5'(i + 10), '0, 64'(i + 100), 5'd0, 5'd0);
            tick();
        end
        check("wrap_cnt", {60'h0, wb_count}, 64'h0);
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd10, 5'd21);
        #1;
        check("wrap_r10", id_rs1data, 64'd100);
        check("wrap_r21", id_rs2data, 64'd111);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 5'd12, '0, 64'h42, 5'd0, 5'd0);
            tick();
        end
        check("pre_async_cnt", {60'h0, wb_count}, 64'h3);

        // Asynchronous reset mid-cycle with a write pending: clears immediately.
        drive(1'b1, 1'b0, 5'd3, '0, 64'h42, 5'd3, 5'd7);
        #1 rst_n = 1'b0;
        #1;
        check("async_cnt", {60'h0, wb_count}, 64'h0);
        check("async_rs1_nobyp", id_rs1data, 64'h0);
        check("async_rs2", id_rs2data, 64'h0);
        tick();
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd3, 5'd12);
        #1 rst_n = 1'b1;
        tick();
        check("after_async_r3", id_rs1data, 64'h0);
        check("after_async_r12", id_rs2data, 64'h0);
        check("after_async_cnt", {60'h0, wb_count}, 64'h0);

        // First edge after deassertion commits normally.
        drive(1'b1, 1'b0, 5'd12, '0, 64'h5A5A, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, '0, '0, 5'd12, 5'd0);
        #1;
        check("first_commit_r12", id_rs1data, 64'h5A5A);
        check("first_commit_cnt", {60'h0, wb_count}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value (memory data or ALU result) and commits it into the 32-entry integer register file.
- Serves the two decode-stage read ports with write-through bypass, so an ID read of a register written in the same cycle returns the new value.
- Exports the writeback value for EX forwarding and keeps a retired-write counter for performance monitoring.

Parameters:
- XLEN, 64, datapath width in bits.
- NREG, 32, number of architectural registers; index width is log2(NREG)=5.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- WB_MemtoReg  in  1  1 = write WB_MemData, 0 = write WB_ALUresult.
- WB_RegWrite  in  1  writeback enable.
- WB_MemData  in  XLEN  load data from MEM/WB.
- WB_ALUresult  in  XLEN  ALU result from MEM/WB.
- WB_rdReg  in  5  destination register index.
- ID_rs1Reg  in  5  read port 1 index.
- ID_rs2Reg  in  5  read port 2 index.
- ID_rs1Data  out  XLEN  read port 1 data.
- ID_rs2Data  out  XLEN  read port 2 data.
- WB_WriteData  out  XLEN  selected writeback value, used for forwarding.
- wb_count  out  CNT_W  count of committed register writes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All NREG entries clear to 0.
  - wb_count clears to 0.
  - Bypass is disabled, so ID_rs1Data and ID_rs2Data read 0.
  - WB_WriteData is purely combinational and is not gated by reset.
- WB_WriteData = WB_MemtoReg ? WB_MemData : WB_ALUresult. It is combinational with 0-cycle latency.
- Commit condition: we = WB_RegWrite && (WB_rdReg != 0).
  - On a rising clk edge with we=1 and rst_n=1: regs[WB_rdReg] <= WB_WriteData.
  - Register visible in the array from the next cycle.
- x0 is hardwired to 0:
  - Writes to index 0 are dropped.
  - Reads of index 0 return 0 regardless of bypass.
- Read ports are combinational and evaluated independently for rs1 and rs2:
  - If rsN == 0, the port returns 0.
  - Otherwise, if rst_n && we && rsN == WB_rdReg, the port returns WB_WriteData (write-through bypass).
  - Otherwise the port returns regs[rsN].
- Both read ports may address the same register, or the register being written, in the same cycle; both must return identical values.
- wb_count increments by 1 on every rising edge where we=1 and rst_n=1.
  - It wraps from 2^CNT_W-1 to 0.
  - Writes to x0 are not counted.
- Reset asserted mid-write: the reset wins. The array and counter are 0 after deassertion, and the write that coincided with reset is lost.
- Reset deassertion: the first edge with rst_n=1 commits normally.
- Inputs X while WB_RegWrite=0 must not corrupt state. The data mux may propagate X to WB_WriteData only.
- No stall input: MEM/WB holds or bubbles by driving WB_RegWrite=0.

Decomposition:
- Shared package (riscv_pkg):
  - XLEN=64 and REG_IDX_W=5.
  - NREG=32 and REG_ZERO=5'd0.
  - A typedef for the register index.
  - A typedef for the XLEN word.
- One natural sub-module, regfile_read_port, holds the zero check plus bypass plus array mux. It is instantiated twice, for rs1 and rs2.
- The writeback mux and counter stay in the top module.

Test Plan:
- Reset check: assert rst_n=0 with WB_RegWrite=1, WB_rdReg=5, WB_ALUresult=0xDEAD -> ID_rs1Data=0 and wb_count=0. After release, reading x5 returns 0.
- ALU write: WB_RegWrite=1, WB_MemtoReg=0, rd=3, ALUresult=0x1234, one edge -> next cycle with rs1=3, ID_rs1Data=0x1234; wb_count=1.
- Memory write with bypass: WB_MemtoReg=1, rd=7, MemData=0xFFFF_FFFF_0000_0001, rs1=rs2=7 in the same cycle -> both read ports equal 0xFFFF_FFFF_0000_0001 before the edge; the array holds it after the edge.
- x0 protection: write rd=0, ALUresult=0xAAAA -> reads of x0 return 0 both before and after the edge; wb_count is unchanged.
- Disabled write: WB_RegWrite=0, rd=9, ALUresult=0x55 with rs2=9 -> ID_rs2Data keeps its old value (0) and no bypass occurs; WB_WriteData=0x55.
- Counter wrap with CNT_W=4: 16 valid writes -> wb_count returns to 0. Assert reset asynchronously mid-cycle -> wb_count=0 immediately, without waiting for a clock edge.
